// File: rtl/valid_pipe_credit_adapter_pkg.sv
// Width helpers shared by the credit adapter and its result FIFO.
package valid_pipe_credit_adapter_pkg;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cred_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_result_fifo.sv
// Synchronous result FIFO with explicit occupancy count; head is read combinationally.
module pipe_result_fifo
  import valid_pipe_credit_adapter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int PW = ptr_w(DEPTH),
  localparam int CW = cred_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             not_empty,
  output logic             overflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_nxt;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & (count != '0);
  // A pop frees the slot in the same cycle, so a full FIFO still takes a write alongside it.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + CW'(1);
    end else if (do_pop && !do_push) begin
      count_nxt = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      not_empty <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      count     <= count_nxt;
      not_empty <= (count_nxt != '0);
      if (push && full && !do_pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/valid_pipe_credit_adapter.sv
// Ready/valid wrapper around a fixed-latency non-stallable pipeline: credits meter
// admission so every in-flight result is guaranteed a slot in the result FIFO.
module valid_pipe_credit_adapter
  import valid_pipe_credit_adapter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 3,
  parameter int DEPTH   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] pipe_x,
  output logic             pipe_input_valid,
  input  logic [WIDTH-1:0] pipe_out,
  input  logic             pipe_output_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow_err
);

  localparam int CW = cred_w(DEPTH);

  logic [CW-1:0]      credits;
  logic [CW-1:0]      credits_nxt;
  logic [CW-1:0]      count;
  logic               accept;
  logic               pop;
  logic [LATENCY-1:0] acc_hist;

  assign in_ready         = rst_n & (credits != '0);
  assign accept           = in_valid & in_ready;
  assign pop              = out_valid & out_ready;
  assign pipe_x           = in_data;
  assign pipe_input_valid = accept;

  always_comb begin
    credits_nxt = credits;
    if (accept && !pop) begin
      credits_nxt = credits - CW'(1);
    end else if (pop && !accept) begin
      credits_nxt = credits + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credits <= CW'(DEPTH);
    end else begin
      credits <= credits_nxt;
    end
  end

  pipe_result_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pipe_output_valid),
    .wdata     (pipe_out),
    .pop       (pop),
    .head      (out_data),
    .count     (count),
    .not_empty (out_valid),
    .overflow  (overflow_err)
  );

  // Shadow of admissions, used only to check the pipeline honours its fixed latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_hist <= '0;
    end else begin
      acc_hist[0] <= accept;
      for (int i = 1; i < LATENCY; i++) begin
        acc_hist[i] <= acc_hist[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!acc_hist[LATENCY-1] || pipe_output_valid);
    end
  end

endmodule

// File: tb/tb_valid_pipe_credit_adapter.sv
// Directed and random checks of the credit adapter wrapped around a model of the foo pipeline.
module tb_valid_pipe_credit_adapter;

  localparam int WIDTH   = 32;
  localparam int LATENCY = 3;
  localparam int DEPTH   = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] pipe_x;
  logic             pipe_input_valid;
  logic [WIDTH-1:0] pipe_out;
  logic             pipe_output_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             overflow_err;
  logic             force_pov;

  logic [WIDTH-1:0] d0, d1, d2;
  logic [2:0]       v;

  int               n_checks = 0;
  int               n_errors = 0;
  int               pops = 0;
  logic [31:0]      exp_q[$];

  always #5 clk = ~clk;

  valid_pipe_credit_adapter #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY),
    .DEPTH   (DEPTH)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .pipe_x            (pipe_x),
    .pipe_input_valid  (pipe_input_valid),
    .pipe_out          (pipe_out),
    .pipe_output_valid (pipe_output_valid),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .overflow_err      (overflow_err)
  );

  // foo pipeline: x+1, then +1 on the upper 31 bits, registered over 3 stages
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v <= '0;
    end else begin
      v[0] <= pipe_input_valid;
      v[1] <= v[0];
      v[2] <= v[1];
    end
    d0 <= pipe_x + 32'd1;
    d1 <= {d0[31:1] + 31'd1, d0[0]};
    d2 <= d1;
  end

  assign pipe_out          = d2;
  assign pipe_output_valid = v[2] | force_pov;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: expected result is (x+1)+2 in acceptance order
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        pops++;
        if (exp_q.size() == 0) check("stale_result", 32'd1, 32'd0);
        else                   check("result_order", out_data, exp_q.pop_front());
      end
      if (pipe_input_valid) exp_q.push_back(in_data + 32'd3);
    end
  end

  initial begin
    int acc;
    int p0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = '0;
    out_ready = 1'b0;
    force_pov = 1'b0;

    // Reset state
    tick(3);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_pipe_iv", 32'(pipe_input_valid), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_overflow", 32'(overflow_err), 32'd0);
    check("rst_credits", 32'(dut.credits), 32'd8);

    // Single operand 5 -> 8
    rst_n     = 1'b1;
    in_data   = 32'h5;
    out_ready = 1'b1;
    #1;
    check("single_in_ready", 32'(in_ready), 32'd1);
    check("single_pipe_iv", 32'(pipe_input_valid), 32'd1);
    check("single_pipe_x", pipe_x, 32'h5);
    tick();
    in_valid = 1'b0;
    check("single_credits_c1", 32'(dut.credits), 32'd7);
    for (int c = 1; c < 4; c++) begin
      check("single_early_valid", 32'(out_valid), 32'd0);
      tick();
    end
    check("single_valid_c4", 32'(out_valid), 32'd1);
    check("single_data_c4", out_data, 32'h8);
    tick();
    check("single_valid_c5", 32'(out_valid), 32'd0);
    check("single_credits_c5", 32'(dut.credits), 32'd8);

    // Streaming 0..99 at full rate
    p0 = pops;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data  = i;
      #1;
      check("stream_in_ready", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    tick(8);
    check("stream_count", pops - p0, 32'd100);
    check("stream_credits", 32'(dut.credits), 32'd8);

    // Backpressure: exactly DEPTH admitted
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h100 + i;
      #1;
      if (pipe_input_valid) acc++;
      tick();
    end
    in_valid = 1'b0;
    check("bp_accepted", acc, 32'd8);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    tick(5);
    check("bp_fifo_count", 32'(dut.u_fifo.count), 32'd8);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_no_overflow", 32'(overflow_err), 32'd0);
    check("bp_credits", 32'(dut.credits), 32'd0);

    // Forced write into a full FIFO
    force_pov = 1'b1;
    tick();
    force_pov = 1'b0;
    check("ovf_set", 32'(overflow_err), 32'd1);
    check("ovf_count", 32'(dut.u_fifo.count), 32'd8);
    tick(3);
    check("ovf_sticky", 32'(overflow_err), 32'd1);

    // Drain in order; credit returns the cycle after the first pop
    p0 = pops;
    out_ready = 1'b1;
    #1;
    check("drain_ready_c0", 32'(in_ready), 32'd0);
    tick();
    check("drain_ready_c1", 32'(in_ready), 32'd1);
    tick(10);
    check("drain_count", pops - p0, 32'd8);
    check("drain_empty", 32'(out_valid), 32'd0);

    // Reset mid-stream: 4 buffered, 3 in flight
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_clears_ovf", 32'(overflow_err), 32'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h200 + i;
      tick();
    end
    in_valid = 1'b0;
    check("mid_buffered", 32'(dut.u_fifo.count), 32'd4);
    check("mid_credits", 32'(dut.credits), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("mid_out_valid", 32'(out_valid), 32'd0);
    check("mid_credits_rst", 32'(dut.credits), 32'd8);
    check("mid_in_ready", 32'(in_ready), 32'd1);
    p0 = pops;
    out_ready = 1'b1;
    tick(10);
    check("mid_no_stale", pops - p0, 32'd0);

    // Random traffic, 30% consumer duty
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = $urandom();
      out_ready = ($urandom_range(0, 99) < 30);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick(20);
    check("rand_drained", exp_q.size(), 32'd0);
    check("rand_no_overflow", 32'(overflow_err), 32'd0);
    check("rand_credits", 32'(dut.credits), 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
